// File: rtl/axi_slave_wr_arbiter.sv
// Write-path arbiter for one NOC slave port: round-robin AW sharing between 4 masters,
// W steering in AW-grant order through an index FIFO, and BID-based B routing.
module axi_slave_wr_arbiter #(
  parameter int unsigned ID_W        = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  // AW, master side
  input  logic [3:0]               m_awvalid,
  output logic [3:0]               m_awready,
  input  logic [4*ID_W-1:0]        m_awid,
  input  logic [4*ADDR_W-1:0]      m_awaddr,
  input  logic [4*8-1:0]           m_awlen,
  // AW, slave side
  output logic                     s_awvalid,
  input  logic                     s_awready,
  output logic [ID_W+1:0]          s_awid,
  output logic [ADDR_W-1:0]        s_awaddr,
  output logic [7:0]               s_awlen,
  // W, master side
  input  logic [3:0]               m_wvalid,
  input  logic [3:0]               m_wlast,
  output logic [3:0]               m_wready,
  input  logic [4*DATA_W-1:0]      m_wdata,
  input  logic [4*(DATA_W/8)-1:0]  m_wstrb,
  // W, slave side
  output logic                     s_wvalid,
  output logic                     s_wlast,
  input  logic                     s_wready,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [DATA_W/8-1:0]      s_wstrb,
  // B, slave side
  input  logic                     s_bvalid,
  output logic                     s_bready,
  input  logic [ID_W+1:0]          s_bid,
  input  logic [1:0]               s_bresp,
  // B, master side
  output logic [3:0]               m_bvalid,
  input  logic [3:0]               m_bready,
  output logic [ID_W-1:0]          m_bid,
  output logic [1:0]               m_bresp
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WFIFO_DEPTH);

  typedef enum logic {
    IDLE,
    AW_OUT
  } aw_state_e;

  aw_state_e state_q, state_d;

  logic [ID_W-1:0]   awid_a   [4];
  logic [ADDR_W-1:0] awaddr_a [4];
  logic [7:0]        awlen_a  [4];
  logic [DATA_W-1:0] wdata_a  [4];
  logic [STRB_W-1:0] wstrb_a  [4];

  logic [1:0]        rr_ptr_q;
  logic [1:0]        gnt_idx;
  logic              gnt_found;
  logic              grant;

  logic [ID_W+1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [7:0]        aw_len_q;

  logic [1:0]        fifo_mem [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [1:0]        head;

  logic [1:0]        b_idx;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      awid_a[i]   = m_awid[i*ID_W +: ID_W];
      awaddr_a[i] = m_awaddr[i*ADDR_W +: ADDR_W];
      awlen_a[i]  = m_awlen[i*8 +: 8];
      wdata_a[i]  = m_wdata[i*DATA_W +: DATA_W];
      wstrb_a[i]  = m_wstrb[i*STRB_W +: STRB_W];
    end
  end

  // First requester at or after rr_ptr; 2-bit index arithmetic gives the modulo-4 wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!gnt_found && m_awvalid[rr_ptr_q + 2'(k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_ptr_q + 2'(k);
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    m_awready = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found && !fifo_full) begin
          grant              = 1'b1;
          m_awready[gnt_idx] = 1'b1;
          state_d            = AW_OUT;
        end
      end
      AW_OUT: begin
        if (s_awready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_ptr_q  <= gnt_idx + 2'd1;
        aw_id_q   <= {gnt_idx, awid_a[gnt_idx]};
        aw_addr_q <= awaddr_a[gnt_idx];
        aw_len_q  <= awlen_a[gnt_idx];
      end
    end
  end

  assign s_awvalid = (state_q == AW_OUT);
  assign s_awid    = aw_id_q;
  assign s_awaddr  = aw_addr_q;
  assign s_awlen   = aw_len_q;

  // Order FIFO of granted master indices; the head owns the slave W channel.
  assign push = grant;
  assign pop  = s_wvalid & s_wready & s_wlast;

  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= gnt_idx;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    m_wready = '0;
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    s_wdata  = wdata_a[head];
    s_wstrb  = wstrb_a[head];
    if (!fifo_empty) begin
      s_wvalid       = m_wvalid[head];
      s_wlast        = m_wlast[head];
      m_wready[head] = s_wready;
    end
  end

  assign b_idx = s_bid[ID_W+1:ID_W];

  always_comb begin
    m_bvalid        = '0;
    m_bvalid[b_idx] = s_bvalid;
  end

  assign s_bready = m_bready[b_idx];
  assign m_bid    = s_bid[ID_W-1:0];
  assign m_bresp  = s_bresp;

endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// Self-checking bench for axi_slave_wr_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then a randomized phase.
module tb_axi_slave_wr_arbiter;

  localparam int ID_W        = 4;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 64;
  localparam int WFIFO_DEPTH = 4;
  localparam int STRB_W      = DATA_W / 8;

  logic                    ACLK;
  logic                    ARESET;
  logic [3:0]              m_awvalid;
  logic [3:0]              m_awready;
  logic [4*ID_W-1:0]       m_awid;
  logic [4*ADDR_W-1:0]     m_awaddr;
  logic [4*8-1:0]          m_awlen;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [ID_W+1:0]         s_awid;
  logic [ADDR_W-1:0]       s_awaddr;
  logic [7:0]              s_awlen;
  logic [3:0]              m_wvalid;
  logic [3:0]              m_wlast;
  logic [3:0]              m_wready;
  logic [4*DATA_W-1:0]     m_wdata;
  logic [4*STRB_W-1:0]     m_wstrb;
  logic                    s_wvalid;
  logic                    s_wlast;
  logic                    s_wready;
  logic [DATA_W-1:0]       s_wdata;
  logic [STRB_W-1:0]       s_wstrb;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ID_W+1:0]         s_bid;
  logic [1:0]              s_bresp;
  logic [3:0]              m_bvalid;
  logic [3:0]              m_bready;
  logic [ID_W-1:0]         m_bid;
  logic [1:0]              m_bresp;

  axi_slave_wr_arbiter #(
    .ID_W        (ID_W),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WFIFO_DEPTH (WFIFO_DEPTH)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awid    (m_awid),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awid    (s_awid),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .m_wvalid  (m_wvalid),
    .m_wlast   (m_wlast),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wlast   (s_wlast),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bid     (s_bid),
    .s_bresp   (s_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bid     (m_bid),
    .m_bresp   (m_bresp)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of granted masters, pending-AW record and round-robin pointer.
  logic [1:0]        mq [$];
  int                mrr;
  bit                mpend;
  bit                model_ok;
  logic [ID_W+1:0]   mid;
  logic [ADDR_W-1:0] maddr;
  logic [7:0]        mlen;

  initial begin
    model_ok = 1'b0;
    mpend    = 1'b0;
    mrr      = 0;
  end

  always @(negedge ACLK) begin : model
    int win;
    int h;
    int bi;
    logic [3:0] e_awr;
    logic [3:0] e_wr;
    logic [3:0] e_bv;
    logic       e_wv;

    win = -1;
    if (!mpend && (m_awvalid != 4'b0) && (mq.size() < WFIFO_DEPTH)) begin
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && m_awvalid[(mrr + k) % 4]) win = (mrr + k) % 4;
      end
    end
    e_awr = 4'b0;
    if (win >= 0) e_awr[win] = 1'b1;

    h = (mq.size() > 0) ? int'(mq[0]) : -1;
    e_wr = 4'b0;
    e_wv = 1'b0;
    if (h >= 0) begin
      e_wr[h] = s_wready;
      e_wv    = m_wvalid[h];
    end

    bi = int'(s_bid[ID_W+1:ID_W]);
    e_bv = 4'b0;
    e_bv[bi] = s_bvalid;

    if (model_ok) begin
      chk("m_awready", 64'(m_awready), 64'(e_awr));
      chk("s_awvalid", 64'(s_awvalid), 64'(mpend));
      if (mpend) begin
        chk("s_awid",   64'(s_awid),   64'(mid));
        chk("s_awaddr", 64'(s_awaddr), 64'(maddr));
        chk("s_awlen",  64'(s_awlen),  64'(mlen));
      end
      chk("s_wvalid", 64'(s_wvalid), 64'(e_wv));
      chk("m_wready", 64'(m_wready), 64'(e_wr));
      if (h >= 0 && m_wvalid[h]) begin
        chk("s_wlast", 64'(s_wlast), 64'(m_wlast[h]));
        chk("s_wdata", s_wdata, m_wdata[h*DATA_W +: DATA_W]);
        chk("s_wstrb", 64'(s_wstrb), 64'(m_wstrb[h*STRB_W +: STRB_W]));
      end
      chk("m_bvalid", 64'(m_bvalid), 64'(e_bv));
      chk("s_bready", 64'(s_bready), 64'(m_bready[bi]));
      chk("m_bid",    64'(m_bid),    64'(s_bid[ID_W-1:0]));
      chk("m_bresp",  64'(m_bresp),  64'(s_bresp));
    end

    // Inputs are stable until after the next rising edge, so advance the model now.
    if (ARESET) begin
      mq.delete();
      mrr      = 0;
      mpend    = 1'b0;
      mid      = '0;
      maddr    = '0;
      mlen     = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (h >= 0 && m_wvalid[h] && s_wready && m_wlast[h]) void'(mq.pop_front());
      if (mpend && s_awready) mpend = 1'b0;
      if (win >= 0) begin
        mq.push_back(2'(win));
        mpend = 1'b1;
        mid   = {2'(win), m_awid[win*ID_W +: ID_W]};
        maddr = m_awaddr[win*ADDR_W +: ADDR_W];
        mlen  = m_awlen[win*8 +: 8];
        mrr   = (win + 1) % 4;
      end
    end
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic at_neg;
    @(negedge ACLK);
  endtask

  task automatic clear_inputs;
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0;
    s_awready = 1'b0;
    m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_wstrb = '0;
    s_wready = 1'b0;
    s_bvalid = 1'b0; s_bid = '0; s_bresp = '0; m_bready = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
  endtask

  int         gidx [8];
  int         gcyc [8];
  int         gcnt;
  logic [3:0] hs;

  initial begin
    clear_inputs();
    ARESET = 1'b1;

    // Reset state
    tick();
    at_neg();
    chk("reset_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("reset_m_awready", 64'(m_awready), 64'd0);
    chk("reset_s_wvalid",  64'(s_wvalid),  64'd0);
    chk("reset_m_wready",  64'(m_wready),  64'd0);
    tick();
    ARESET = 1'b0;

    // Single request from master 0
    m_awvalid = 4'b0001;
    m_awid[3:0] = 4'd3;
    m_awaddr[31:0] = 32'h100;
    m_awlen[7:0] = 8'd3;
    at_neg();
    chk("t1_m_awready", 64'(m_awready), 64'b0001);
    tick();
    m_awvalid = 4'b0;
    s_awready = 1'b1;
    at_neg();
    chk("t1_s_awvalid", 64'(s_awvalid), 64'd1);
    chk("t1_s_awid",    64'(s_awid),    64'b00_0011);
    chk("t1_s_awaddr",  64'(s_awaddr),  64'h100);
    chk("t1_s_awlen",   64'(s_awlen),   64'd3);
    tick();
    s_awready = 1'b0;
    m_wvalid = 4'b0001;
    s_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_wlast[0] = (b == 3);
      m_wdata[63:0] = 64'hA0 + 64'(b);
      m_wstrb[7:0] = 8'hFF;
      at_neg();
      chk("t1_m_wready", 64'(m_wready), 64'b0001);
      chk("t1_s_wdata",  s_wdata, 64'hA0 + 64'(b));
      chk("t1_s_wlast",  64'(s_wlast), 64'(b == 3));
      tick();
    end
    m_wlast = '0;
    at_neg();
    chk("t1_popped_s_wvalid", 64'(s_wvalid), 64'd0);
    chk("t1_popped_m_wready", 64'(m_wready), 64'd0);
    tick();
    m_wvalid = '0;
    s_bvalid = 1'b1;
    s_bid = 6'b00_0011;
    s_bresp = 2'b10;
    m_bready = 4'b0001;
    at_neg();
    chk("t1_m_bvalid", 64'(m_bvalid), 64'b0001);
    chk("t1_m_bid",    64'(m_bid),    64'd3);
    chk("t1_s_bready", 64'(s_bready), 64'd1);
    tick();

    // All four masters requesting continuously
    do_reset();
    m_awvalid = 4'b1111;
    s_awready = 1'b1;
    m_wvalid = 4'b1111;
    m_wlast = 4'b1111;
    s_wready = 1'b1;
    gcnt = 0;
    for (int i = 0; i < 8; i++) begin gidx[i] = 7; gcyc[i] = -100; end
    for (int c = 0; c < 10; c++) begin
      at_neg();
      if (m_awready != 4'b0 && gcnt < 8) begin
        for (int i = 0; i < 4; i++) if (m_awready[i]) gidx[gcnt] = i;
        gcyc[gcnt] = c;
        gcnt++;
      end
      tick();
    end
    chk("t2_grant_count", 64'(gcnt), 64'd5);
    chk("t2_grant0", 64'(gidx[0]), 64'd0);
    chk("t2_grant1", 64'(gidx[1]), 64'd1);
    chk("t2_grant2", 64'(gidx[2]), 64'd2);
    chk("t2_grant3", 64'(gidx[3]), 64'd3);
    chk("t2_grant4", 64'(gidx[4]), 64'd0);
    for (int k = 1; k < 5; k++) chk("t2_grant_gap", 64'(gcyc[k] - gcyc[k-1]), 64'd2);

    // Fairness from rr_ptr=2
    do_reset();
    s_awready = 1'b1;
    m_wvalid = 4'b1111;
    m_wlast = 4'b1111;
    s_wready = 1'b1;
    m_awvalid = 4'b0001;
    at_neg();
    chk("t3_first", 64'(m_awready), 64'b0001);
    tick(); tick();
    m_awvalid = 4'b0010;
    at_neg();
    chk("t3_second", 64'(m_awready), 64'b0010);
    tick(); tick();
    m_awvalid = 4'b1011;
    at_neg();
    chk("t3_rr2_winner", 64'(m_awready), 64'b1000);
    tick(); tick();
    at_neg();
    chk("t3_after_wrap", 64'(m_awready), 64'b0001);
    tick();

    // FIFO full
    do_reset();
    s_awready = 1'b1;
    m_awvalid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("t4_fill_grant", 64'(m_awready), 64'(4'b0001 << k));
      tick();
      if (k == 3) m_awvalid = 4'b0010;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("t4_full_stall", 64'(m_awready), 64'd0);
      tick();
    end
    m_wvalid = 4'b0001;
    m_wlast = 4'b0001;
    s_wready = 1'b1;
    at_neg();
    chk("t4_pop_cycle_awready", 64'(m_awready), 64'd0);
    chk("t4_pop_cycle_wready",  64'(m_wready),  64'b0001);
    tick();
    m_wvalid = '0;
    m_wlast = '0;
    at_neg();
    chk("t4_grant_after_pop", 64'(m_awready), 64'b0010);
    tick();
    m_awvalid = '0;
    tick();

    // Slave AW backpressure
    do_reset();
    m_awvalid = 4'b0101;
    m_awid[3:0] = 4'd5;   m_awaddr[31:0] = 32'hDEAD_0000;  m_awlen[7:0] = 8'd7;
    m_awid[11:8] = 4'd9;  m_awaddr[95:64] = 32'h2000;      m_awlen[23:16] = 8'd1;
    at_neg();
    chk("t5_grant", 64'(m_awready), 64'b0001);
    tick();
    m_awvalid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      m_awaddr[31:0] = $urandom;
      m_awid[3:0] = 4'($urandom);
      m_awlen[7:0] = 8'($urandom);
      at_neg();
      chk("t5_hold_s_awvalid", 64'(s_awvalid), 64'd1);
      chk("t5_hold_s_awid",    64'(s_awid),    64'b00_0101);
      chk("t5_hold_s_awaddr",  64'(s_awaddr),  64'hDEAD_0000);
      chk("t5_hold_s_awlen",   64'(s_awlen),   64'd7);
      chk("t5_no_grant",       64'(m_awready), 64'd0);
      tick();
    end
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    at_neg();
    chk("t5_next_grant", 64'(m_awready), 64'b0100);
    tick();

    // Reset mid-burst after beat 2 of 4
    do_reset();
    s_awready = 1'b1;
    m_awvalid = 4'b0010;
    m_awlen[15:8] = 8'd3;
    at_neg();
    chk("t6_grant", 64'(m_awready), 64'b0010);
    tick();
    m_awvalid = '0;
    m_wvalid = 4'b0010;
    s_wready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      at_neg();
      chk("t6_beat_wready", 64'(m_wready), 64'b0010);
      tick();
    end
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    m_awvalid = 4'b0100;
    at_neg();
    chk("t6_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("t6_s_wvalid",  64'(s_wvalid),  64'd0);
    chk("t6_m_wready",  64'(m_wready),  64'd0);
    chk("t6_m2_first",  64'(m_awready), 64'b0100);
    tick();
    clear_inputs();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      hs = m_awvalid & m_awready;
      @(posedge ACLK);
      #1;
      ARESET = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++) begin
        if (hs[i] || !m_awvalid[i]) begin
          m_awvalid[i] = ($urandom_range(0, 2) == 0);
          m_awid[i*ID_W +: ID_W] = ID_W'($urandom);
          m_awaddr[i*ADDR_W +: ADDR_W] = $urandom;
          m_awlen[i*8 +: 8] = 8'($urandom);
        end
        m_wvalid[i] = ($urandom_range(0, 1) == 0);
        m_wlast[i] = ($urandom_range(0, 3) == 0);
        m_wstrb[i*STRB_W +: STRB_W] = STRB_W'($urandom);
      end
      for (int i = 0; i < 4 * DATA_W / 32; i++) m_wdata[i*32 +: 32] = $urandom;
      s_awready = ($urandom_range(0, 3) != 0);
      s_wready = ($urandom_range(0, 3) != 0);
      s_bvalid = ($urandom_range(0, 1) == 0);
      s_bid = (ID_W + 2)'($urandom);
      s_bresp = 2'($urandom);
      m_bready = 4'($urandom);
    end
    at_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_slave_wr_arbiter.md
Name: axi_slave_wr_arbiter

Overview:
- Write-path arbiter and scheduler for one slave port of the 4-master / 7-slave AXI NOC. Instantiated once per slave.
- Shares the slave's AW channel between 4 masters using round-robin.
- Steers W beats in AW-grant order through an order FIFO.
- Routes B responses back to the issuing master using master-index bits prepended to AWID.

Parameters:
- ID_W, 4, master-side AXI ID width; slave-side ID width is ID_W+2.
- ADDR_W, 32, address width.
- DATA_W, 64, data width; WSTRB width is DATA_W/8.
- WFIFO_DEPTH, 4, W-order FIFO depth; power of 2, minimum 2.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- m_awvalid  in  4  per-master AW valid.
- m_awready  out  4  per-master AW ready.
- m_awid  in  4*ID_W  packed AWID; master i occupies slice i.
- m_awaddr  in  4*ADDR_W  packed AWADDR.
- m_awlen  in  4*8  packed AWLEN.
- s_awvalid  out  1  slave AW valid.
- s_awready  in  1  slave AW ready.
- s_awid  out  ID_W+2  {master_idx, AWID}.
- s_awaddr  out  ADDR_W  forwarded address.
- s_awlen  out  8  forwarded length.
- m_wvalid / m_wlast  in  4 / 4  per-master W valid and last.
- m_wready  out  4  per-master W ready.
- m_wdata  in  4*DATA_W  packed write data.
- m_wstrb  in  4*DATA_W/8  packed write strobes.
- s_wvalid / s_wlast  out  1 / 1  slave W valid and last.
- s_wready  in  1  slave W ready.
- s_wdata / s_wstrb  out  DATA_W / DATA_W/8  muxed write data and strobes.
- s_bvalid  in  1  slave B valid.
- s_bready  out  1  slave B ready.
- s_bid  in  ID_W+2  slave BID.
- s_bresp  in  2  slave BRESP.
- m_bvalid  out  4  per-master B valid.
- m_bready  in  4  per-master B ready.
- m_bid  out  ID_W  BID with routing bits stripped.
- m_bresp  out  2  BRESP, broadcast to all masters.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - rr_ptr=0, FSM=IDLE, FIFO empty (count=0).
  - s_awvalid=0, AW output register=0.
  - Combinational outputs follow these reset states: m_awready=0, m_wready=0, s_wvalid=0.
  - Reset mid-burst discards all in-flight state; no completion is generated.
- AW FSM, two states:
  - IDLE: grant enabled when any m_awvalid=1 and FIFO count<WFIFO_DEPTH.
    - Winner g is the first requester at or after rr_ptr, searching modulo 4.
    - m_awready[g]=1 combinationally in that cycle; all other bits 0.
    - At the edge: latch {g, m_awid[g]}, m_awaddr[g], m_awlen[g] into the output register; push g into the FIFO; rr_ptr<=(g+1)%4; go to AW_OUT.
  - AW_OUT: s_awvalid=1 and register contents held stable. On s_awready=1, return to IDLE.
    - No new grant is issued in AW_OUT.
  - Latency: grant in cycle N gives s_awvalid in cycle N+1. Maximum sustained rate is 1 AW per 2 cycles.
- W steering, combinational, zero added latency:
  - FIFO empty: s_wvalid=0 and m_wready=0.
  - Otherwise, with h = FIFO head: s_w* = m_w*[h], m_wready[h]=s_wready, other m_wready bits=0.
  - Pop when s_wvalid & s_wready & s_wlast.
  - Push and pop in the same cycle leaves count unchanged and is legal even when full.
  - A W beat may precede its AW on the slave side only if its index is already in the FIFO. A master's W is never forwarded before its AW grant.
- B routing:
  - idx = s_bid[ID_W+1:ID_W].
  - m_bvalid[idx]=s_bvalid; all other m_bvalid bits 0.
  - s_bready=m_bready[idx].
  - m_bid=s_bid[ID_W-1:0].
- FIFO full: AW grants stall while full. A pop frees the slot for a grant in the next cycle.
- The block makes no protocol checks. Behaviour is undefined if a master drops m_wlast or m_awvalid illegally.

Test Plan:
- Reset, then single request: m_awvalid=4'b0001, awid=3, awaddr=0x100, awlen=3. Required:
  - m_awready[0]=1 at cycle N.
  - s_awvalid=1 at N+1 with s_awid=6'b00_0011.
  - 4 W beats forwarded, FIFO pops on the last beat.
  - B with s_bid=6'b00_0011 gives m_bvalid=4'b0001 and m_bid=3.
- All four masters request continuously, s_awready=1. Required grant order 0,1,2,3,0 on alternate cycles, with rr_ptr wrapping from 3 to 0.
- Fairness: rr_ptr=2 and requests 4'b1011 → master 3 granted; next grant is master 0.
- FIFO full: 4 AWs granted, no W sent, m_awvalid[1]=1 pending. Required:
  - m_awready=0 while full.
  - Completing one burst's wlast produces a grant in the next cycle.
- Backpressure: s_awready=0 for 5 cycles. Required: s_awvalid, s_awid, s_awaddr and s_awlen held stable, no other m_awready asserted.
- Reset mid-burst, after beat 2 of 4: next cycle s_awvalid=0, s_wvalid=0, m_wready=0; a subsequent request from master 2 is granted first.
